arb2_stream: RTL and testbench
==============================

# arb2_stream

Two-input round-robin stream arbiter with packet lock and a one-beat registered output stage. It sits directly upstream of the 2:1 selection datapath. It decides which of two valid/ready sources (A, B) owns the shared channel, drives the select line (0 = A, 1 = B), and forwards the chosen beat through the datapath into a single output register. A grant is held for a whole packet, delimited by `last`.

## Interface
- `WIDTH`, default 8: data width per beat.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a_valid`  in  1: source A has a beat.
- `a_ready`  out  1: A beat accepted this cycle when `a_valid && a_ready`.
- `a_data`  in  WIDTH: A payload.
- `a_last`  in  1: final beat of A's packet.
- `b_valid`, `b_ready`, `b_data`, `b_last`: same as A, for source B.
- `out_valid`  out  1: output register holds a beat.
- `out_ready`  in  1: sink accepts when `out_valid && out_ready`.
- `out_data`  out  WIDTH: registered payload.
- `out_last`  out  1: registered last flag.
- `sel`  out  1: current grant (0 = A, 1 = B); drives the mux datapath.
- `busy`  out  1: high in LOCK_A or LOCK_B.

## Operation
- FSM states: IDLE, LOCK_A, LOCK_B. One priority flop `last_grant`.
- **IDLE grant** (combinational):
  - only A valid -> A;
  - only B valid -> B;
  - both valid -> the source other than `last_grant`;
  - none valid -> `sel` = 0.
- **LOCK_x**: the grant is fixed to x. The other source sees ready = 0 regardless of its valid.
- `load = granted_valid && (!out_valid || out_ready)`.
- `x_ready = (grant == x) && (!out_valid || out_ready)`.
- **On load**:
  - `out_data` and `out_last` are taken from the granted source;
  - `out_valid` <= 1.
- **Without load**: `out_valid` <= `out_valid && !out_ready`.
- **Transitions on a load from x**:
  - `last` = 0: IDLE -> LOCK_x (LOCK_x stays in LOCK_x).
  - `last` = 1: next state is IDLE and `last_grant` <= x. This applies from IDLE and from LOCK_x.
- `last_grant` changes only on a last-beat transfer. A stall never rotates priority.
- A packet of length 1 (`last` = 1 on the first beat) never enters a LOCK state.
- **Reset values**:
  - state IDLE; `last_grant` = B, so A wins the first tie;
  - `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0.
  - `sel` = 0 and both readies = 0 until a source is valid.
- **Reset mid-packet**: the lock is dropped and the held output beat is discarded. No recovery of the partial packet.

## Timing
- Latency: input acceptance at edge N -> `out_valid` / `out_data` visible after edge N.
- Throughput: one beat per cycle while `out_ready` = 1. Back-to-back packets from alternating sources have no bubble.
- `a_ready`, `b_ready` and `sel` are combinational from state, `last_grant`, the valids and `out_valid` / `out_ready`. There is no combinational path from the data inputs.
- `out_*` and `busy` are registered. `busy` reflects the state after the edge.
- **Simultaneous output drain and load**: allowed in the same cycle (full-throughput case).
- **`out_ready` low with `out_valid` = 1**:
  - `out_data` and `out_last` hold;
  - both readies are 0;
  - the state holds.
- **Source drops valid mid-packet in LOCK_x**: no transfer; the lock is held indefinitely.

## Structure
- Package `arb2_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_t`;
  - `localparam GRANT_A = 1'b0`, `GRANT_B = 1'b1`.
- Datapath: WIDTH+1 instances of the team's existing `mux2_1` cell (data bits plus `last`) in a generate loop, all driven by `sel`, feeding the output register.
- Arbitration FSM and output register live in the top module. No other sub-modules.

## Test plan
1. **Async reset**: assert `rst_n` low mid-cycle with `out_valid` = 1 -> all outputs 0 immediately; after release, the first tie goes to A.
2. **Single beat from A**: `a_data` = 0x3C, `a_last` = 1, `out_ready` = 1 -> next cycle `out_data` = 0x3C, `out_last` = 1, `sel` = 0, `busy` = 0.
3. **Tie rotation**: A (0x11) and B (0x22) continuously valid with single-beat packets -> output sequence 0x11, 0x22, 0x11, 0x22 on consecutive cycles.
4. **Packet lock**: A sends 0xA0, 0xA1, 0xA2 (`last` on 0xA2) while B is valid with 0xB0 ->
   - `b_ready` = 0 for three cycles;
   - `busy` = 1 after the first beat;
   - 0xB0 is output in the fourth slot.
5. **Backpressure**: hold `out_ready` = 0 for 4 cycles with 0x55 in the register and A valid -> `out_data` stays 0x55 and `a_ready` = 0; on release, no beat is lost or duplicated.
6. **Reset mid-packet**: reset after beat 2 of a 3-beat B packet -> returns to IDLE with `out_valid` = 0; a subsequent A beat is granted immediately.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared types and constants for the two-input packet arbiter.
package arb2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } arb_state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 selection cell: o_y follows i_a when i_sel is 0, i_b when 1.
module mux2_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/arb2_stream.sv
// Two-source round-robin stream arbiter with packet lock, feeding a bit-sliced
// 2:1 datapath and a single registered output beat.
module arb2_stream
    import arb2_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sel,
    output logic             busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_busy;

    logic             w_grant;
    logic             w_grant_valid;
    logic             w_space;
    logic             w_offer;
    logic             w_load;
    logic [WIDTH:0]   w_mux_a;
    logic [WIDTH:0]   w_mux_b;
    logic [WIDTH:0]   w_mux_y;

    // Bit WIDTH of each mux bus carries the packet's last flag.
    assign w_mux_a = {a_last, a_data};
    assign w_mux_b = {b_last, b_data};

    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_mux
        mux2_1 u_mux (
            .i_a   (w_mux_a[gi]),
            .i_b   (w_mux_b[gi]),
            .i_sel (w_grant),
            .o_y   (w_mux_y[gi])
        );
    end

    always_comb begin
        w_grant = GRANT_A;
        unique case (r_state)
            LOCK_A: w_grant = GRANT_A;
            LOCK_B: w_grant = GRANT_B;
            default: begin
                if (a_valid && b_valid) begin
                    w_grant = ~r_last_grant;
                end else if (b_valid) begin
                    w_grant = GRANT_B;
                end else begin
                    w_grant = GRANT_A;
                end
            end
        endcase
    end

    assign w_grant_valid = (w_grant == GRANT_B) ? b_valid : a_valid;
    assign w_space       = !r_out_valid || out_ready;
    // In IDLE nothing is offered until some source is actually valid.
    assign w_offer       = w_space && ((r_state != IDLE) || a_valid || b_valid);
    assign w_load        = w_grant_valid && w_space;

    assign a_ready = w_offer && (w_grant == GRANT_A);
    assign b_ready = w_offer && (w_grant == GRANT_B);

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        if (w_load) begin
            if (w_mux_y[WIDTH]) begin
                w_state_nxt      = IDLE;
                w_last_grant_nxt = w_grant;
            end else begin
                w_state_nxt = (w_grant == GRANT_B) ? LOCK_B : LOCK_A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_B;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_y[WIDTH-1:0];
                r_out_last  <= w_mux_y[WIDTH];
            end else begin
                r_out_valid <= r_out_valid && !out_ready;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sel       = w_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_arb2_stream.sv
// Scoreboard bench for arb2_stream: directed scenarios followed by random
// packet traffic, checked against a packet-level round-robin model.
module tb_arb2_stream;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_ready, a_last;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_last;
    logic [7:0] b_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic       sel, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_owner 0 = nobody holds the channel, 1 = A mid-packet, 2 = B mid-packet.
    int         m_owner;
    bit         m_lg;
    bit         m_ov;
    bit         acc_a, acc_b;
    logic [8:0] exp_q[$];
    logic [8:0] qa[$];
    logic [8:0] qb[$];

    arb2_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_last    (b_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Output monitor: every accepted output beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_beat: got %0h, expected none at %0t", {out_last, out_data}, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    n_bad++;
                    $display("FAIL out_beat: got %0h, expected %0h at %0t",
                             {out_last, out_data}, e, $time);
                end
            end
        end
    end

    task automatic set_in(input bit av, input logic [7:0] ad, input bit al,
                          input bit bv, input logic [7:0] bd, input bit bl, input bit ordy);
        a_valid = av; a_data = ad; a_last = al;
        b_valid = bv; b_data = bd; b_last = bl;
        out_ready = ordy;
    endtask

    // One clock: predict arbitration on the current inputs, then check registered outputs.
    task automatic tick();
        bit         g, space, offer, load;
        logic [8:0] beat;
        #1;
        if (m_owner == 1)              g = 1'b0;
        else if (m_owner == 2)         g = 1'b1;
        else if (a_valid && b_valid)   g = !m_lg;
        else if (b_valid)              g = 1'b1;
        else                           g = 1'b0;
        space = !m_ov || out_ready;
        offer = space && (m_owner != 0 || a_valid || b_valid);
        chk("a_ready", a_ready, offer && !g);
        chk("b_ready", b_ready, offer && g);
        chk("sel", sel, g);
        load  = (g ? b_valid : a_valid) && space;
        beat  = g ? {b_last, b_data} : {a_last, a_data};
        acc_a = load && !g;
        acc_b = load && g;
        if (load) begin
            exp_q.push_back(beat);
            if (beat[8]) begin
                m_owner = 0;
                m_lg    = g;
            end else begin
                m_owner = g ? 2 : 1;
            end
            m_ov = 1'b1;
        end else begin
            m_ov = m_ov && !out_ready;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, m_owner != 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        exp_q.delete();
        m_owner = 0;
        m_lg    = 1'b1;
        m_ov    = 1'b0;
        acc_a   = 1'b0;
        acc_b   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_pkt(input bit is_b);
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            logic [8:0] bt;
            bt = {(i == n - 1) ? 1'b1 : 1'b0, 8'($urandom)};
            if (is_b) qb.push_back(bt);
            else      qa.push_back(bt);
        end
    endtask

    initial begin
        logic [7:0] rot [4];
        rst_n = 1'b1;
        set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);
        do_reset();

        // Async reset while the output register holds a beat.
        set_in(1, 8'h99, 1, 0, 8'h00, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 0, 8'h00, 0, 0);
        do_reset();

        // Tie rotation from reset: A wins first.
        rot[0] = 8'h11; rot[1] = 8'h22; rot[2] = 8'h11; rot[3] = 8'h22;
        set_in(1, 8'h11, 1, 1, 8'h22, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rotation", out_data, rot[i]);
        end

        // Packet lock: three-beat A packet holds off B.
        set_in(1, 8'hA0, 0, 1, 8'hB0, 1, 1);
        tick();
        chk("lock_busy", busy, 1);
        a_data = 8'hA1;
        tick();
        a_data = 8'hA2; a_last = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        chk("lock_b_slot4", out_data, 8'hB0);

        // Single beat from A.
        set_in(1, 8'h3C, 1, 0, 8'h00, 0, 1);
        tick();
        chk("single_data", out_data, 8'h3C);
        chk("single_last", out_last, 1);
        a_valid = 1'b0;
        #1;
        chk("single_sel", sel, 0);
        chk("single_busy", busy, 0);

        // Backpressure with 0x55 held.
        set_in(1, 8'h55, 1, 0, 8'h00, 0, 1);
        tick();
        set_in(1, 8'h66, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_a_ready", a_ready, 0);
            tick();
            chk("bp_hold", out_data, 8'h55);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next", out_data, 8'h66);
        a_valid = 1'b0;
        tick();

        // Reset after two beats of a three-beat B packet.
        set_in(0, 8'h00, 0, 1, 8'hB1, 0, 1);
        tick();
        b_data = 8'hB2;
        tick();
        do_reset();
        set_in(1, 8'h77, 1, 0, 8'h00, 0, 1);
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        tick();
        chk("post_rst_data", out_data, 8'h77);
        set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);
        tick();

        // Random packet traffic.
        acc_a = 1'b0;
        acc_b = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            bit hold_a, hold_b;
            hold_a = a_valid && !acc_a;
            hold_b = b_valid && !acc_b;
            if (acc_a) void'(qa.pop_front());
            if (acc_b) void'(qb.pop_front());
            if (qa.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(1'b0);
            if (qb.size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(1'b1);
            a_valid = hold_a || (qa.size() != 0 && $urandom_range(0, 3) != 0);
            b_valid = hold_b || (qb.size() != 0 && $urandom_range(0, 3) != 0);
            if (qa.size() != 0) {a_last, a_data} = qa[0];
            else                {a_last, a_data} = 9'($urandom);
            if (qb.size() != 0) {b_last, b_data} = qb[0];
            else                {b_last, b_data} = 9'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain whatever is left in the output register.
        set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
